// File: rtl/sti_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module   : sti_pixel_packer
// Purpose  : Repacks the STI serializer bit stream (MSB first) into 8-bit
//            pixels and writes them sequentially into pixel memory. At frame
//            end it flushes any partial pixel left-aligned, then fills every
//            remaining address with FILL_VAL and raises pixel_finish.
// Ports    : clk           - rising-edge clock
//            reset         - asynchronous active-low reset
//            so_data       - serial bit, sampled when so_valid=1
//            so_valid      - serial bit qualifier
//            frame_end     - level, high once the last serializer word issued
//            pixel_wr      - one-cycle registered write strobe
//            pixel_addr    - write address (ADDR_W bits), held between writes
//            pixel_dataout - write data (8 bits), held between writes
//            pixel_finish  - sticky, whole memory has been written
//            overflow      - sticky, serial bits were dropped
// Revision : 1.0 - initial release
// ============================================================================
module sti_pixel_packer #(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [7:0]  FILL_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              so_data,
  input  logic              so_valid,
  input  logic              frame_end,
  output logic              pixel_wr,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [7:0]        pixel_dataout,
  output logic              pixel_finish,
  output logic              overflow
);

  localparam int unsigned       C_CNT_W = ADDR_W + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_FILL    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           sreg_q, sreg_d;
  logic [2:0]           bitcnt_q, bitcnt_d;
  logic [C_CNT_W-1:0]   bytecnt_q, bytecnt_d;
  logic                 wr_pend_q, wr_pend_d;
  logic                 pixel_wr_q, pixel_wr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic                 finish_q, finish_d;
  logic                 overflow_q, overflow_d;
  logic                 valid_prev_q, valid_prev_d;

  // Bytes already written plus the one whose strobe is still pending. Using
  // this for the full test drops bits that arrive while the 256th write is
  // in flight, before bytecnt itself has caught up.
  logic [C_CNT_W-1:0]   w_committed;
  logic                 w_mem_full;
  logic [7:0]           w_shifted;
  logic [3:0]           w_pad;
  logic [7:0]           w_partial;
  logic                 w_final_fall;

  assign w_committed  = bytecnt_q + {{ADDR_W{1'b0}}, wr_pend_q};
  assign w_mem_full   = (w_committed == C_DEPTH);
  assign w_shifted    = {sreg_q[6:0], so_data};
  // Partial pixel lives in the low bitcnt bits; shift it up to MSB position.
  assign w_pad        = 4'd8 - {1'b0, bitcnt_q};
  assign w_partial    = sreg_q << w_pad;
  // Frame ends on the falling edge of so_valid while frame_end is high.
  assign w_final_fall = frame_end & ~so_valid & valid_prev_q;

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bitcnt_d     = bitcnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    finish_d     = finish_q;
    overflow_d   = overflow_q;
    valid_prev_d = so_valid;
    // A pending write always becomes the strobe on the following edge, and
    // the byte counter advances at that same edge.
    wr_pend_d    = 1'b0;
    pixel_wr_d   = wr_pend_q;
    bytecnt_d    = w_committed;

    case (state_q)
      ST_COLLECT: begin
        if (w_final_fall) begin
          state_d = ST_FLUSH;
        end else if (so_valid) begin
          if (w_mem_full) begin
            overflow_d = 1'b1;
          end else begin
            sreg_d   = w_shifted;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              data_d    = w_shifted;
              addr_d    = bytecnt_q[ADDR_W-1:0];
              wr_pend_d = 1'b1;
            end
          end
        end
      end

      ST_FLUSH: begin
        if (so_valid) begin
          overflow_d = 1'b1;
        end
        // Wait for any byte still pending from COLLECT before using bytecnt.
        if (!wr_pend_q) begin
          if (bitcnt_q != 3'd0) begin
            bitcnt_d = 3'd0;
            if (w_mem_full) begin
              overflow_d = 1'b1;
            end else begin
              data_d    = w_partial;
              addr_d    = bytecnt_q[ADDR_W-1:0];
              wr_pend_d = 1'b1;
            end
          end else begin
            state_d = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        if (so_valid) begin
          overflow_d = 1'b1;
        end
        // Loading on the edge that drops the previous strobe gives one
        // write every two cycles.
        if (!wr_pend_q) begin
          if (bytecnt_q != C_DEPTH) begin
            data_d    = FILL_VAL;
            addr_d    = bytecnt_q[ADDR_W-1:0];
            wr_pend_d = 1'b1;
          end else if (!pixel_wr_q) begin
            state_d  = ST_DONE;
            finish_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (so_valid) begin
          overflow_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_COLLECT;
      sreg_q       <= 8'h00;
      bitcnt_q     <= 3'd0;
      bytecnt_q    <= '0;
      wr_pend_q    <= 1'b0;
      pixel_wr_q   <= 1'b0;
      addr_q       <= '0;
      data_q       <= 8'h00;
      finish_q     <= 1'b0;
      overflow_q   <= 1'b0;
      valid_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bitcnt_q     <= bitcnt_d;
      bytecnt_q    <= bytecnt_d;
      wr_pend_q    <= wr_pend_d;
      pixel_wr_q   <= pixel_wr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      finish_q     <= finish_d;
      overflow_q   <= overflow_d;
      valid_prev_q <= valid_prev_d;
    end
  end

  assign pixel_wr      = pixel_wr_q;
  assign pixel_addr    = addr_q;
  assign pixel_dataout = data_q;
  assign pixel_finish  = finish_q;
  assign overflow      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sti_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sti_pixel_packer
// Purpose  : Self-checking bench for sti_pixel_packer. A frame-level model
//            turns the transmitted bit list into the expected write list
//            (bytes, left-aligned partial, fill) that every observed strobe
//            is compared against, plus literal timing/value pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sti_pixel_packer;

  localparam int         ADDR_W   = 8;
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [7:0] FILL_VAL = 8'h00;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              so_data = 1'b0;
  logic              so_valid = 1'b0;
  logic              frame_end = 1'b0;
  logic              pixel_wr;
  logic [ADDR_W-1:0] pixel_addr;
  logic [7:0]        pixel_dataout;
  logic              pixel_finish;
  logic              overflow;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t        exp_q[$];
  bit         frame_bits[$];
  bit         exp_ovf;
  logic [7:0] exp_mem [DEPTH];
  logic [7:0] mem     [DEPTH];
  bit         written [DEPTH];
  int         wr_cyc  [DEPTH];
  int         writes_seen = 0;
  int         cyc = 0;
  logic       prev_wr = 1'b0;

  sti_pixel_packer #(.ADDR_W(ADDR_W), .FILL_VAL(FILL_VAL)) dut (
    .clk          (clk),
    .reset        (reset),
    .so_data      (so_data),
    .so_valid     (so_valid),
    .frame_end    (frame_end),
    .pixel_wr     (pixel_wr),
    .pixel_addr   (pixel_addr),
    .pixel_dataout(pixel_dataout),
    .pixel_finish (pixel_finish),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Every strobe seen on the falling edge must be the next expected write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset && pixel_wr) begin
        writes_seen++;
        check("wr_gap", {31'd0, prev_wr}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: actual addr=%0h data=%0h required=no write",
                   pixel_addr, pixel_dataout);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", {24'd0, pixel_addr}, {24'd0, w.addr});
          check("wr_data", {24'd0, pixel_dataout}, {24'd0, w.data});
        end
        mem[pixel_addr]     = pixel_dataout;
        written[pixel_addr] = 1'b1;
        wr_cyc[pixel_addr]  = cyc;
      end
      prev_wr = pixel_wr;
    end
  end

  task automatic push_bits(input logic [31:0] val, input int n);
    for (int k = n - 1; k >= 0; k--) frame_bits.push_back(val[k]);
  endtask

  // Frame model: whole bytes, then a zero-padded tail, then fill, all capped
  // at the memory depth; any bit beyond depth*8 means overflow.
  task automatic build_model();
    int   n;
    int   nb;
    int   rem;
    int   a;
    logic [7:0] b;
    wr_t  w;
    n   = frame_bits.size();
    nb  = n / 8;
    rem = n % 8;
    a   = 0;
    exp_q.delete();
    for (int i = 0; i < nb && a < DEPTH; i++) begin
      b = 8'h00;
      for (int k = 0; k < 8; k++) b = {b[6:0], frame_bits[i*8+k]};
      w.addr = a[ADDR_W-1:0]; w.data = b; exp_q.push_back(w); exp_mem[a] = b; a++;
    end
    if (rem != 0 && a < DEPTH) begin
      b = 8'h00;
      for (int k = 0; k < rem; k++) b[7-k] = frame_bits[nb*8+k];
      w.addr = a[ADDR_W-1:0]; w.data = b; exp_q.push_back(w); exp_mem[a] = b; a++;
    end
    while (a < DEPTH) begin
      w.addr = a[ADDR_W-1:0]; w.data = FILL_VAL; exp_q.push_back(w); exp_mem[a] = FILL_VAL; a++;
    end
    exp_ovf = (n > DEPTH * 8);
  endtask

  task automatic do_reset(input string tag);
    so_valid  = 1'b0;
    so_data   = 1'b0;
    frame_end = 1'b0;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check({tag, "_rst_wr"},     {31'd0, pixel_wr},      32'd0);
    check({tag, "_rst_addr"},   {24'd0, pixel_addr},    32'd0);
    check({tag, "_rst_data"},   {24'd0, pixel_dataout}, 32'd0);
    check({tag, "_rst_finish"}, {31'd0, pixel_finish},  32'd0);
    check({tag, "_rst_ovf"},    {31'd0, overflow},      32'd0);
    exp_q.delete();
    frame_bits.delete();
    for (int i = 0; i < DEPTH; i++) begin
      written[i] = 1'b0;
      mem[i]     = 8'h00;
      wr_cyc[i]  = 0;
    end
    writes_seen = 0;
    reset = 1'b1;
    tick();
  endtask

  // Streams frame_bits with an optional so_valid gap, then ends the frame by
  // dropping so_valid together with raising frame_end.
  task automatic run_frame(input int gap_after, input int gap_len);
    for (int i = 0; i < frame_bits.size(); i++) begin
      so_valid = 1'b1;
      so_data  = frame_bits[i];
      tick();
      if (i + 1 == gap_after) begin
        so_valid = 1'b0;
        repeat (gap_len) tick();
      end
    end
    so_valid  = 1'b0;
    so_data   = 1'b0;
    frame_end = 1'b1;
    tick();
  endtask

  task automatic finish_frame(input string tag);
    int n;
    n = 0;
    while (!pixel_finish && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_finish"}, {31'd0, pixel_finish}, 32'd1);
    repeat (4) tick();
    check({tag, "_pending"}, exp_q.size(), 32'd0);
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    for (int i = 0; i < DEPTH; i++)
      check({tag, "_mem"}, {23'd0, written[i], mem[i]}, {23'd0, 1'b1, exp_mem[i]});
  endtask

  initial begin
    // 1: two full bytes, remainder filled
    do_reset("t1");
    push_bits(32'hA53C, 16);
    build_model();
    run_frame(0, 0);
    finish_frame("t1");
    check("t1_mem0", {24'd0, mem[0]}, 32'hA5);
    check("t1_mem1", {24'd0, mem[1]}, 32'h3C);
    check("t1_fill_rate", wr_cyc[255] - wr_cyc[2], 32'd506);

    // 2: pixel spanning a so_valid gap plus a 3-bit tail
    do_reset("t2");
    push_bits(32'b1011_0011_101, 11);
    build_model();
    run_frame(5, 3);
    finish_frame("t2");
    check("t2_mem0", {24'd0, mem[0]}, 32'hB3);
    check("t2_mem1", {24'd0, mem[1]}, 32'hA0);

    // 3: write timing relative to the edge sampling the 8th bit
    do_reset("t3");
    push_bits(32'hFF, 8);
    build_model();
    for (int i = 0; i < 8; i++) begin
      so_valid = 1'b1;
      so_data  = frame_bits[i];
      tick();
    end
    so_valid  = 1'b0;
    so_data   = 1'b0;
    frame_end = 1'b1;
    @(negedge clk);
    check("t3_addr_N",  {24'd0, pixel_addr},    32'h00);
    check("t3_data_N",  {24'd0, pixel_dataout}, 32'hFF);
    check("t3_wr_N",    {31'd0, pixel_wr},      32'd0);
    @(negedge clk);
    check("t3_wr_N1",   {31'd0, pixel_wr},      32'd1);
    @(negedge clk);
    check("t3_wr_N2",   {31'd0, pixel_wr},      32'd0);
    #2;
    finish_frame("t3");

    // 4: more bytes than memory holds
    do_reset("t4");
    for (int i = 0; i < 258; i++) push_bits(32'h5A, 8);
    build_model();
    run_frame(0, 0);
    finish_frame("t4");
    check("t4_ovf_lit", {31'd0, overflow}, 32'd1);
    check("t4_mem255", {24'd0, mem[255]}, 32'h5A);

    // 5: asynchronous reset while a strobe is in flight, then a fresh frame
    do_reset("t5");
    for (int i = 0; i < 5; i++) push_bits(32'hC3, 8);
    build_model();
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    for (int i = 0; i < 40; i++) begin
      so_valid = 1'b1;
      so_data  = frame_bits[i];
      tick();
    end
    so_data = 1'b1;
    @(posedge clk);
    #3;
    check("t5_wr_inflight", {31'd0, pixel_wr}, 32'd1);
    check("t5_writes_before", writes_seen, 32'd4);
    check("t5_unseen", exp_q.size(), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_async_wr",   {31'd0, pixel_wr},      32'd0);
    check("t5_async_addr", {24'd0, pixel_addr},    32'd0);
    check("t5_async_data", {24'd0, pixel_dataout}, 32'd0);
    check("t5_async_fin",  {31'd0, pixel_finish},  32'd0);
    check("t5_async_ovf",  {31'd0, overflow},      32'd0);
    so_valid = 1'b0;
    so_data  = 1'b0;
    do_reset("t5b");
    push_bits(32'h12, 8);
    build_model();
    run_frame(0, 0);
    finish_frame("t5b");
    check("t5_mem0", {24'd0, mem[0]}, 32'h12);

    // 6: frame_end with no preceding so_valid fall does nothing
    do_reset("t6");
    frame_end = 1'b1;
    repeat (50) tick();
    check("t6_writes", writes_seen, 32'd0);
    check("t6_finish", {31'd0, pixel_finish}, 32'd0);
    frame_end = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
